// File: rtl/mult_drv_pkg.sv
// rtl/mult_drv_pkg.sv - shared types and helpers for the multiplier request driver
package mult_drv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RES,
        HOLD_OUT
    } state_t;

    localparam int STATUS_ARG_PERR = 0;
    localparam int STATUS_RES_PERR = 1;
    localparam int STATUS_TIMEOUT  = 2;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  inject;
    } fifo_entry_t;

    function automatic logic parity16(input logic [15:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mult_drv_fifo.sv
// rtl/mult_drv_fifo.sv - synchronous operand FIFO with full/empty flags
module mult_drv_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0]
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mult_req_driver.sv
// rtl/mult_req_driver.sv - feeds a parity-protected multiplier from an operand stream
module mult_req_driver
    import mult_drv_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [1:0]  in_inject_err,
    output logic        mult_req,
    output logic [15:0] mult_arg_a,
    output logic        mult_arg_a_parity,
    output logic [15:0] mult_arg_b,
    output logic        mult_arg_b_parity,
    input  logic        mult_ack,
    input  logic [31:0] mult_result,
    input  logic        mult_result_parity,
    input  logic        mult_result_rdy,
    input  logic        mult_arg_parity_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_status,
    output logic        busy
);
    localparam logic [7:0] TIMEOUT_LAST   = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] TIMEOUT_STATUS = 3'b001 << STATUS_TIMEOUT;

    state_t      state;
    state_t      state_next;
    fifo_entry_t push_entry;
    fifo_entry_t head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic [7:0]  cnt;
    logic [7:0]  cnt_next;
    logic        req_next;
    logic [15:0] a_next;
    logic [15:0] b_next;
    logic        pa_next;
    logic        pb_next;
    logic        valid_next;
    logic [31:0] result_next;
    logic [2:0]  status_next;
    logic [2:0]  cap_status;

    assign push_entry = '{a: in_a, b: in_b, inject: in_inject_err};
    assign in_ready   = !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;

    mult_drv_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fifo_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        cap_status                  = '0;
        cap_status[STATUS_ARG_PERR] = mult_arg_parity_error;
        cap_status[STATUS_RES_PERR] = (^mult_result) != mult_result_parity;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            mult_req          <= 1'b0;
            mult_arg_a        <= '0;
            mult_arg_b        <= '0;
            mult_arg_a_parity <= 1'b0;
            mult_arg_b_parity <= 1'b0;
            out_valid         <= 1'b0;
            out_result        <= '0;
            out_status        <= '0;
        end else begin
            state             <= state_next;
            cnt               <= cnt_next;
            mult_req          <= req_next;
            mult_arg_a        <= a_next;
            mult_arg_b        <= b_next;
            mult_arg_a_parity <= pa_next;
            mult_arg_b_parity <= pb_next;
            out_valid         <= valid_next;
            out_result        <= result_next;
            out_status        <= status_next;
        end
    end

    // A new pop only happens from IDLE, so one multiplier transaction is in flight at most.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        req_next    = mult_req;
        a_next      = mult_arg_a;
        b_next      = mult_arg_b;
        pa_next     = mult_arg_a_parity;
        pb_next     = mult_arg_b_parity;
        valid_next  = out_valid;
        result_next = out_result;
        status_next = out_status;
        pop         = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    a_next     = head.a;
                    b_next     = head.b;
                    pa_next    = parity16(head.a) ^ head.inject[0];
                    pb_next    = parity16(head.b) ^ head.inject[1];
                    req_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                cnt_next = cnt + 8'd1;
                if (mult_ack) begin
                    req_next = 1'b0;
                    if (mult_result_rdy) begin
                        result_next = mult_result;
                        status_next = cap_status;
                        valid_next  = 1'b1;
                        state_next  = HOLD_OUT;
                    end else begin
                        cnt_next   = '0;
                        state_next = WAIT_RES;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    req_next    = 1'b0;
                    result_next = '0;
                    status_next = TIMEOUT_STATUS;
                    valid_next  = 1'b1;
                    state_next  = HOLD_OUT;
                end
            end
            WAIT_RES: begin
                cnt_next = cnt + 8'd1;
                if (mult_result_rdy) begin
                    result_next = mult_result;
                    status_next = cap_status;
                    valid_next  = 1'b1;
                    state_next  = HOLD_OUT;
                end else if (cnt == TIMEOUT_LAST) begin
                    result_next = '0;
                    status_next = TIMEOUT_STATUS;
                    valid_next  = 1'b1;
                    state_next  = HOLD_OUT;
                end
            end
            HOLD_OUT: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_req_driver.sv
// tb/tb_mult_req_driver.sv - self-checking bench with a behavioural multiplier and scoreboard
module tb_mult_req_driver;

    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [1:0]  in_inject_err;
    logic        mult_req;
    logic [15:0] mult_arg_a;
    logic        mult_arg_a_parity;
    logic [15:0] mult_arg_b;
    logic        mult_arg_b_parity;
    logic        mult_ack;
    logic [31:0] mult_result;
    logic        mult_result_parity;
    logic        mult_result_rdy;
    logic        mult_arg_parity_error;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_status;
    logic        busy;

    mult_req_driver #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_a                  (in_a),
        .in_b                  (in_b),
        .in_inject_err         (in_inject_err),
        .mult_req              (mult_req),
        .mult_arg_a            (mult_arg_a),
        .mult_arg_a_parity     (mult_arg_a_parity),
        .mult_arg_b            (mult_arg_b),
        .mult_arg_b_parity     (mult_arg_b_parity),
        .mult_ack              (mult_ack),
        .mult_result           (mult_result),
        .mult_result_parity    (mult_result_parity),
        .mult_result_rdy       (mult_result_rdy),
        .mult_arg_parity_error (mult_arg_parity_error),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_result            (out_result),
        .out_status            (out_status),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit no_ack;
        bit same_cycle;
        bit corrupt;
        int ack_dly;
        int res_dly;
    } cfg_t;

    typedef struct {
        logic [31:0] result;
        logic [2:0]  status;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  inject;
        cfg_t        cfg;
        logic        pa;
        logic        pb;
        logic [31:0] result;
        logic [2:0]  status;
    } vec_t;

    cfg_t cfg_q[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic seen_pa;
    logic seen_pb;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic cfg_t mk_cfg(input bit no_ack, input bit same_cycle, input bit corrupt);
        cfg_t c;
        c.no_ack     = no_ack;
        c.same_cycle = same_cycle;
        c.corrupt    = corrupt;
        c.ack_dly    = 2;
        c.res_dly    = 3;
        return c;
    endfunction

    function automatic vec_t mk_vec(input logic [15:0] a, input logic [15:0] b, input logic [1:0] inj,
                                    input cfg_t c, input logic pa, input logic pb,
                                    input logic [31:0] res, input logic [2:0] st);
        vec_t v;
        v.a = a; v.b = b; v.inject = inj; v.cfg = c;
        v.pa = pa; v.pb = pb; v.result = res; v.status = st;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] res, input logic [2:0] st);
        exp_t e;
        e.result = res;
        e.status = st;
        return e;
    endfunction

    // Behavioural multiplier: checks argument parity, answers per the queued config.
    initial begin : model
        cfg_t                c;
        logic                perr;
        logic signed [31:0]  sa;
        logic signed [31:0]  sb;
        logic [31:0]         res;
        int                  n;
        mult_ack              = 1'b0;
        mult_result_rdy       = 1'b0;
        mult_result           = '0;
        mult_result_parity    = 1'b0;
        mult_arg_parity_error = 1'b0;
        forever begin
            tick();
            if (mult_req && !rst) begin
                c = mk_cfg(1'b0, 1'b0, 1'b0);
                if (cfg_q.size() > 0) c = cfg_q.pop_front();
                seen_pa = mult_arg_a_parity;
                seen_pb = mult_arg_b_parity;
                if (c.no_ack) begin
                    n = 0;
                    while (mult_req && n < 100) begin
                        n++;
                        tick();
                    end
                    check("req_high_cycles", n, TO);
                end else begin
                    repeat (c.ack_dly - 1) tick();
                    perr = ((^mult_arg_a) != mult_arg_a_parity) || ((^mult_arg_b) != mult_arg_b_parity);
                    sa   = $signed(mult_arg_a);
                    sb   = $signed(mult_arg_b);
                    res  = perr ? 32'd0 : 32'(sa * sb);
                    mult_ack = 1'b1;
                    if (c.same_cycle) begin
                        mult_result           = res;
                        mult_result_parity    = (^res) ^ c.corrupt;
                        mult_arg_parity_error = perr;
                        mult_result_rdy       = 1'b1;
                    end
                    tick();
                    mult_ack        = 1'b0;
                    mult_result_rdy = 1'b0;
                    if (!c.same_cycle) begin
                        repeat (c.res_dly - 1) tick();
                        mult_result           = res;
                        mult_result_parity    = (^res) ^ c.corrupt;
                        mult_arg_parity_error = perr;
                        mult_result_rdy       = 1'b1;
                        tick();
                        mult_result_rdy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got result %h status %b, expected no output",
                             out_result, out_status);
                end else begin
                    e = sb_q.pop_front();
                    check("out_result", out_result, e.result);
                    check("out_status", 32'(out_status), 32'(e.status));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [1:0] inj);
        int n;
        in_a          = a;
        in_b          = b;
        in_inject_err = inj;
        in_valid      = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("push_in_ready_wait", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb_q.size(), 0);
        tick();
    endtask

    initial begin : stim
        vec_t        vt [7];
        logic [15:0] ra;
        logic [15:0] rb;
        int          ea;
        int          eb;
        int          n;

        vt[0] = mk_vec(16'd3,     16'hFFFE, 2'b00, mk_cfg(0, 0, 0), 1'b0, 1'b1, 32'hFFFF_FFFA, 3'b000);
        vt[1] = mk_vec(16'h00FF,  16'd5,    2'b01, mk_cfg(0, 0, 0), 1'b1, 1'b0, 32'h0000_0000, 3'b001);
        vt[2] = mk_vec(16'd2,     16'd3,    2'b00, mk_cfg(0, 0, 1), 1'b1, 1'b0, 32'h0000_0006, 3'b010);
        vt[3] = mk_vec(16'hFFFF,  16'hFFFF, 2'b10, mk_cfg(0, 0, 0), 1'b0, 1'b1, 32'h0000_0000, 3'b001);
        vt[4] = mk_vec(16'h7FFF,  16'h7FFF, 2'b00, mk_cfg(0, 1, 0), 1'b1, 1'b1, 32'h3FFF_0001, 3'b000);
        vt[5] = mk_vec(16'h8000,  16'h7FFF, 2'b00, mk_cfg(0, 0, 0), 1'b1, 1'b1, 32'hC000_8000, 3'b000);
        vt[6] = mk_vec(16'd1,     16'd1,    2'b00, mk_cfg(1, 0, 0), 1'b1, 1'b1, 32'h0000_0000, 3'b100);

        rst           = 1'b1;
        in_valid      = 1'b0;
        in_a          = '0;
        in_b          = '0;
        in_inject_err = '0;
        out_ready     = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_mult_req",   32'(mult_req),   32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_out_result", out_result,      32'd0);
        check("rst_out_status", 32'(out_status), 32'd0);
        check("rst_arg_a",      32'(mult_arg_a), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            cfg_q.push_back(vt[i].cfg);
            sb_q.push_back(mk_exp(vt[i].result, vt[i].status));
            in_a          = vt[i].a;
            in_b          = vt[i].b;
            in_inject_err = vt[i].inject;
            in_valid      = 1'b1;
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            check("req_latency_1", 32'(mult_req), 32'd0);
            @(negedge clk);
            check("req_latency_2", 32'(mult_req), 32'd1);
            tick();
            wait_drain();
            check("arg_a_parity", 32'(seen_pa), 32'(vt[i].pa));
            check("arg_b_parity", 32'(seen_pb), 32'(vt[i].pb));
        end

        // Timeout on one entry, then the queued entry behind it is still served.
        cfg_q.push_back(mk_cfg(1, 0, 0));
        cfg_q.push_back(mk_cfg(0, 0, 0));
        sb_q.push_back(mk_exp(32'd0, 3'b100));
        sb_q.push_back(mk_exp(32'd35, 3'b000));
        push(16'd1, 16'd1, 2'b00);
        push(16'd5, 16'd7, 2'b00);
        wait_drain();

        // Back-pressure: one transaction in flight plus a full FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            ea = $signed(ra);
            eb = $signed(rb);
            cfg_q.push_back(mk_cfg(0, 0, 0));
            sb_q.push_back(mk_exp(32'(ea * eb), 3'b000));
            if (i == 5) begin
                @(negedge clk);
                check("fifo_full_in_ready", 32'(in_ready), 32'd0);
                check("fifo_full_busy",     32'(busy),     32'd1);
                tick();
                out_ready = 1'b1;
            end
            push(ra, rb, 2'b00);
        end
        wait_drain();

        // Reset while waiting for the result; the late result must be dropped.
        cfg_q.push_back(mk_cfg(0, 0, 0));
        cfg_q[cfg_q.size()-1].res_dly = 6;
        push(16'd9, 16'd9, 2'b00);
        n = 0;
        while (!mult_req && n < 50) begin tick(); n++; end
        check("rst_test_req_seen", 32'(mult_req), 32'd1);
        n = 0;
        while (mult_req && n < 50) begin tick(); n++; end
        check("rst_test_acked", 32'(mult_req), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_mult_req",  32'(mult_req),  32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        repeat (12) tick();
        @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_busy",      32'(busy),      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
